// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32I-class integer ALU with iterative shifter
// Single-cycle arithmetic/logic/compare/branch ops; shifts move up to SHIFT_STEP bits per cycle.
module alu_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            rd_we,
  output logic            cmp,
  output logic            carry
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP_MAX = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [SW-1:0]   cnt;
  logic [SW-1:0]   step;
  logic [3:0]      sh_op;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic            is_branch;
  logic            is_shift;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic [XLEN-1:0] res;
  logic            res_we;
  logic            res_cmp;
  logic            res_carry;

  assign in_ready  = (state == S_IDLE);
  assign is_branch = (op >= 4'd10);
  assign is_shift  = (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
  assign op2       = (use_imm && !is_branch) ? imm : rs2;
  assign sum       = {1'b0, rs1} + {1'b0, op2};
  assign diff      = {1'b0, rs1} - {1'b0, op2};
  assign lt_s      = $signed(rs1) < $signed(op2);
  assign lt_u      = diff[XLEN];
  assign eq        = (rs1 == op2);

  // Bits moved this cycle: the remaining count, capped at SHIFT_STEP.
  assign step = ({1'b0, cnt} < STEP_MAX) ? cnt : STEP_MAX[SW-1:0];

  always_comb begin
    case (sh_op)
      4'd7:    acc_next = acc << step;
      4'd8:    acc_next = acc >> step;
      default: acc_next = $signed(acc) >>> step;
    endcase
  end

  always_comb begin
    res       = '0;
    res_we    = 1'b1;
    res_cmp   = 1'b0;
    res_carry = 1'b0;
    case (op)
      4'd0: begin res = sum[XLEN-1:0];  res_carry = sum[XLEN];  end
      4'd1: begin res = diff[XLEN-1:0]; res_carry = diff[XLEN]; end
      4'd2: res = rs1 & op2;
      4'd3: res = rs1 | op2;
      4'd4: res = rs1 ^ op2;
      4'd5: res = {{(XLEN-1){1'b0}}, lt_s};
      4'd6: res = {{(XLEN-1){1'b0}}, lt_u};
      4'd7, 4'd8, 4'd9: res = rs1;   // zero shift amount completes immediately
      4'd10: begin res_we = 1'b0; res_cmp = eq;    end
      4'd11: begin res_we = 1'b0; res_cmp = !eq;   end
      4'd12: begin res_we = 1'b0; res_cmp = lt_s;  end
      4'd13: begin res_we = 1'b0; res_cmp = !lt_s; end
      4'd14: begin res_we = 1'b0; res_cmp = lt_u;  end
      default: begin res_we = 1'b0; res_cmp = !lt_u; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      rd        <= '0;
      rd_we     <= 1'b0;
      cmp       <= 1'b0;
      carry     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      sh_op     <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= rs1;
            cnt   <= op2[SW-1:0];
            sh_op <= op;
            if (is_shift && (op2[SW-1:0] != '0)) begin
              state <= S_SHIFT;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              rd        <= res;
              rd_we     <= res_we;
              cmp       <= res_cmp;
              carry     <= res_carry;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - step;
          if (cnt == step) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            rd        <= acc_next;
            rd_we     <= 1'b1;
            cmp       <= 1'b0;
            carry     <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed-vector bench for alu_mc
// Main instance is 32-bit/step 4; two 64-bit instances use step 1 and step 64.
module tb_alu_mc;

  logic        clk, reset, flush, in_valid, in_ready, use_imm, out_valid, out_ready;
  logic        rd_we, cmp, carry;
  logic [3:0]  op;
  logic [31:0] rs1, rs2, imm, rd;

  logic        w_in_valid, w_out_ready;
  logic [3:0]  w_op;
  logic [63:0] w_rs1, w_rs2;
  logic        wa_in_ready, wa_out_valid, wa_rd_we, wa_cmp, wa_carry;
  logic        wb_in_ready, wb_out_valid, wb_rd_we, wb_cmp, wb_carry;
  logic [63:0] wa_rd, wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .rd_we(rd_we), .cmp(cmp), .carry(carry)
  );

  alu_mc #(.XLEN(64), .SHIFT_STEP(1)) dut_w1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(w_in_valid), .in_ready(wa_in_ready),
    .op(w_op), .use_imm(1'b0), .rs1(w_rs1), .rs2(w_rs2), .imm(64'd0),
    .out_valid(wa_out_valid), .out_ready(w_out_ready), .rd(wa_rd), .rd_we(wa_rd_we),
    .cmp(wa_cmp), .carry(wa_carry)
  );

  alu_mc #(.XLEN(64), .SHIFT_STEP(64)) dut_w64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(w_in_valid), .in_ready(wb_in_ready),
    .op(w_op), .use_imm(1'b0), .rs1(w_rs1), .rs2(w_rs2), .imm(64'd0),
    .out_valid(wb_out_valid), .out_ready(w_out_ready), .rd(wb_rd), .rd_we(wb_rd_we),
    .cmp(wb_cmp), .carry(wb_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  o;
    logic        ui;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [31:0] r;
    logic        we;
    logic        c;
    logic        cy;
    logic [7:0]  lat;
  } vec_t;

  localparam vec_t ALU_V [9] = '{
    '{4'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h00000000, 1'b1, 1'b0, 1'b1, 8'd1},
    '{4'd0, 1'b1, 32'd5,        32'd100,      32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b0, 1'b1, 8'd1},
    '{4'd1, 1'b0, 32'd9,        32'd4,        32'd0,        32'h00000005, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd1, 1'b0, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 8'd1},
    '{4'd2, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd3, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hFFF0FFF0, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd5, 1'b0, 32'hFFFFFFFE, 32'd3,        32'd0,        32'h00000001, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd6, 1'b0, 32'hFFFFFFFE, 32'd3,        32'd0,        32'h00000000, 1'b1, 1'b0, 1'b0, 8'd1}
  };

  localparam vec_t BR_V [6] = '{
    '{4'd12, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd1},
    '{4'd14, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'd10, 1'b1, 32'd7,        32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd1},
    '{4'd11, 1'b1, 32'd7,        32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'd13, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'd15, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd1}
  };

  localparam vec_t SH_V [6] = '{
    '{4'd9, 1'b1, 32'h80000000, 32'd0,     32'd9,        32'hFFC00000, 1'b1, 1'b0, 1'b0, 8'd4},
    '{4'd7, 1'b0, 32'h12345678, 32'd0,     32'd0,        32'h12345678, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'd8, 1'b0, 32'h80000000, 32'd31,    32'd0,        32'h00000001, 1'b1, 1'b0, 1'b0, 8'd9},
    '{4'd7, 1'b1, 32'h00000001, 32'd0,     32'h00000025, 32'h00000020, 1'b1, 1'b0, 1'b0, 8'd3},
    '{4'd9, 1'b0, 32'h7FFFFFF0, 32'd4,     32'd0,        32'h07FFFFFF, 1'b1, 1'b0, 1'b0, 8'd2},
    '{4'd8, 1'b0, 32'hCAFEF00D, 32'h00000100, 32'd0,     32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 8'd1}
  };

  task automatic run_op(input logic [3:0] o, input logic ui, input logic [31:0] a, b, i,
                        output int lat);
    @(negedge clk);
    op = o; use_imm = ui; rs1 = a; rs2 = b; imm = i; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, rd, rd_we, cmp, carry} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b rd=%h we=%b cmp=%b cy=%b required 1 0 0 0 0 0",
               in_ready, out_valid, rd, rd_we, cmp, carry);
    end
  endtask

  task automatic test_vectors(input string name, input int n, input int sel);
    vec_t v;
    int   lat;
    for (int k = 0; k < n; k++) begin
      v = (sel == 0) ? ALU_V[k] : (sel == 1) ? BR_V[k] : SH_V[k];
      run_op(v.o, v.ui, v.a, v.b, v.i, lat);
      n_checks++;
      if ({8'(lat), rd, rd_we, cmp, carry} !== {v.lat, v.r, v.we, v.c, v.cy}) begin
        n_fail++;
        $display("FAIL %s[%0d]: lat=%0d rd=%h we=%b cmp=%b cy=%b required lat=%0d rd=%h we=%b cmp=%b cy=%b",
                 name, k, lat, rd, rd_we, cmp, carry, v.lat, v.r, v.we, v.c, v.cy);
      end
      pop();
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s[%0d] release: rdy=%b vld=%b required 1 0", name, k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(4'd1, 1'b0, 32'd5, 32'd7, 32'd0, lat);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({out_valid, in_ready, rd, carry, rd_we} !== {2'b10, 32'hFFFFFFFE, 2'b11}) begin
        n_fail++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b rd=%h cy=%b we=%b required 1 0 fffffffe 1 1",
                 c, out_valid, in_ready, rd, carry, rd_we);
      end
      @(negedge clk);
    end
    op = 4'd0; use_imm = 1'b0; rs1 = 32'd1; rs2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_same_cycle_accept: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, rd} !== {1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL accept_after_idle: vld=%b rd=%h required 1 00000002", out_valid, rd);
    end
    pop();
  endtask

  task automatic test_flush;
    int lat;
    int seen = 0;
    @(negedge clk);
    op = 4'd8; use_imm = 1'b0; rs1 = 32'h80000000; rs2 = 32'd31; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 4'd0; rs1 = 32'd10; rs2 = 32'd10;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_to_idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: out_valid seen %0d cycles required 0", seen);
    end
    run_op(4'd0, 1'b0, 32'd2, 32'd3, 32'd0, lat);
    n_checks++;
    if ({8'(lat), rd, rd_we} !== {8'd1, 32'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL add_after_flush: lat=%0d rd=%h we=%b required 1 00000005 1", lat, rd, rd_we);
    end
    pop();
  endtask

  task automatic test_reset_mid_shift;
    int seen = 0;
    @(negedge clk);
    op = 4'd8; use_imm = 1'b0; rs1 = 32'h80000000; rs2 = 32'd31; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, rd, rd_we, cmp, carry} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b rd=%h we=%b cmp=%b cy=%b required 1 0 0 0 0 0",
               in_ready, out_valid, rd, rd_we, cmp, carry);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_partial: out_valid seen %0d cycles required 0", seen);
    end
  endtask

  task automatic test_wide;
    logic [3:0]  wo  [3] = '{4'd9, 4'd7, 4'd0};
    logic [63:0] wa  [3] = '{64'h8000000000000000, 64'd1, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] wbv [3] = '{64'd63, 64'd40, 64'd1};
    logic [63:0] wr  [3] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000010000000000, 64'd0};
    int          la_e[3] = '{64, 41, 1};
    int          lb_e[3] = '{2, 2, 1};
    logic        cy_e[3] = '{1'b0, 1'b0, 1'b1};
    int la, lb;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      w_op = wo[k]; w_rs1 = wa[k]; w_rs2 = wbv[k]; w_in_valid = 1'b1;
      @(negedge clk);
      w_in_valid = 1'b0;
      la = 0; lb = 0;
      for (int c = 1; c <= 200 && (la == 0 || lb == 0); c++) begin
        if (la == 0 && wa_out_valid) la = c;
        if (lb == 0 && wb_out_valid) lb = c;
        if (la == 0 || lb == 0) @(negedge clk);
      end
      n_checks++;
      if ({la, wa_rd, wa_carry} !== {la_e[k], wr[k], cy_e[k]}) begin
        n_fail++;
        $display("FAIL wide_step1[%0d]: lat=%0d rd=%h cy=%b required lat=%0d rd=%h cy=%b",
                 k, la, wa_rd, wa_carry, la_e[k], wr[k], cy_e[k]);
      end
      n_checks++;
      if ({lb, wb_rd, wb_carry} !== {lb_e[k], wr[k], cy_e[k]}) begin
        n_fail++;
        $display("FAIL wide_step64[%0d]: lat=%0d rd=%h cy=%b required lat=%0d rd=%h cy=%b",
                 k, lb, wb_rd, wb_carry, lb_e[k], wr[k], cy_e[k]);
      end
      w_out_ready = 1'b1;
      @(negedge clk);
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; use_imm = 1'b0; rs1 = '0; rs2 = '0; imm = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = 4'd0; w_rs1 = '0; w_rs2 = '0;
    test_reset();
    test_vectors("alu", 9, 0);
    test_vectors("branch", 6, 1);
    test_vectors("shift", 6, 2);
    test_back_to_back();
    test_flush();
    test_reset_mid_shift();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
